// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 32x32 multiply / 32/32 divide sequencer that borrows the
// shared ALU for one add or subtract per cycle (shift-add MULU, restoring DIVU).
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_co
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       CTR_IDLE = 3'b000;
  localparam logic [2:0]       CTR_ADD  = 3'b010;
  localparam logic [2:0]       CTR_SUB  = 3'b110;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic [WIDTH-1:0] d_q;

  // Divide step: remainder shifted left by one with the next dividend bit.
  // The bit shifted out of hi guarantees t >= D even when the ALU borrows.
  logic [WIDTH-1:0] rem_shift;
  logic             rem_msb;
  logic             ge;

  assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign rem_msb   = hi[WIDTH-1];
  assign ge        = rem_msb | alu_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctr   = CTR_IDLE;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_b = d_q;
        if (op_q) begin
          alu_a   = rem_shift;
          alu_ctr = CTR_SUB;
        end else begin
          alu_a   = hi;
          alu_ctr = CTR_ADD;
        end
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= 1'b0;
      d_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            d_q  <= b;
            hi   <= '0;
            lo   <= a;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q) begin
            hi <= ge ? alu_res : rem_shift;
            lo <= {lo[WIDTH-2:0], ge};
          end else if (lo[0]) begin
            {hi, lo} <= {alu_co, alu_res, lo[WIDTH-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU, directed and random MULU/DIVU ops,
// expected results queued by the driver and checked by a done-driven monitor.
module tb_alu_muldiv_seq;

  localparam int W = 32;
  localparam int LAT = 33;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_ctr;
  logic [W-1:0]  alu_res;
  logic          alu_co;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_res(alu_res), .alu_co(alu_co)
  );

  // Shared ALU: add, subtract with Co = no-borrow, AND otherwise.
  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    case (alu_ctr)
      3'b010:  {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_res = alu_a & alu_b;
    endcase
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    if (!o) begin
      r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end else if (y == 0) begin
      r = {x, {W{1'b1}}};
    end else begin
      r = {x % y, x / y};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("start_wait_timeout", 64'(busy), 64'(0));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back(model(o, x, y));
    exp_cyc_q.push_back(cyc + LAT);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("completion_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_ignored_start();
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int busy_run = 0;
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    int             ec;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result_hi_lo", {hi, lo}, e);
          check("done_cycle", 64'(cyc), 64'(ec));
          check("busy_length", 64'(busy_run), 64'(LAT));
        end
        busy_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] held;
    int             k;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {32'(busy), 32'(done)}, 64'(0));
    check("reset_hi_lo", {hi, lo}, 64'(0));
    check("reset_alu_drive", {alu_a, 29'(0), alu_ctr}, 64'(0));
    rst_n = 1'b1;

    // Directed cases
    start_op(1'b0, 32'd7, 32'd6);
    wait_idle();
    check("idle_alu_ctr", 64'(alu_ctr), 64'(0));
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_op(1'b1, 32'd100, 32'd7);
    start_op(1'b1, 32'hFFFF_FFFF, 32'd1);
    start_op(1'b1, 32'h1234, 32'd0);
    wait_idle();

    // Starts during RUN and during DONE are dropped
    start_op(1'b1, 32'd1000, 32'd9);
    repeat (10) @(negedge clk);
    pulse_ignored_start();
    k = 0;
    @(negedge clk);
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 64'(1));
    held = model(1'b1, 32'd1000, 32'd9);
    pulse_ignored_start();
    check("busy_after_done_start", 64'(busy), 64'(0));
    @(negedge clk);
    check("hold_after_done", {hi, lo}, held);
    start_op(1'b0, 32'd12345, 32'd678);
    wait_idle();

    // Reset mid-operation
    start_op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {32'(busy), 32'(done)}, 64'(0));
    check("abort_hi_lo", {hi, lo}, 64'(0));
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    start_op(1'b0, 32'd5, 32'd5);
    wait_idle();

    // Random operations
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'($urandom_range(0, 15));
        1:       y = 32'($urandom_range(0, 65535));
        2:       y = x >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      start_op(1'($urandom_range(0, 1)), x, y);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
